// File: rtl/arf_pkg.sv
// ---------------------------------------------------------------------------
// arf_pkg
// Shared definitions for the ARF accuracy harness: the batch FSM state type
// and the native sample width of the arf_variance / arf_accurate outputs.
// Used by the error monitor and its absolute-difference stage, and by the
// ARF stimulus bench.
// ---------------------------------------------------------------------------
package arf_pkg;

   // Native width of one ARF output sample
   localparam int ARF_DATA_W = 64;

   // Batch controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } arf_state_t;

endpackage

// File: rtl/arf_absdiff.sv
// ---------------------------------------------------------------------------
// arf_absdiff
// Registered unsigned magnitude |a - b| with a travelling valid bit.
// The smaller operand is always subtracted from the larger, so the result
// never wraps and fits in W bits.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     operands a/b are meaningful this cycle
//   a, b         unsigned operands
//   out_valid    diff holds the result for an accepted pair
//   diff         |a - b|, registered
// ---------------------------------------------------------------------------
module arf_absdiff
   import arf_pkg::*;
#(
   parameter int W = ARF_DATA_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   output logic [W-1:0] diff
);

   // The magnitude is only captured for accepted pairs so diff keeps the
   // last meaningful value between samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         diff      <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            diff <= (a >= b) ? (a - b) : (b - a);
         end
      end
   end

endmodule

// File: rtl/arf_error_monitor.sv
// ---------------------------------------------------------------------------
// arf_error_monitor
// Compares paired samples of the approximate (arf_variance) and exact
// (arf_accurate) ARF outputs for ports 27 and 28 and gathers per-batch error
// statistics over N_SAMPLES samples.
// Pipeline: accept -> stage 1 (|acc-var| per port, threshold captured)
//                  -> stage 2 (sum/max/mismatch/sample counters).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  clear stats and begin a batch (ignored in RUN)
//   err_thresh             mismatch threshold, captured with each sample
//   in_valid / in_ready    sample handshake
//   out_2x_acc/out_2x_var  exact / approximate outputs for ports 27, 28
//   sum_err_2x             saturating sum of |acc-var|
//   max_err_2x             largest |acc-var| seen
//   mism_cnt               samples where either diff exceeds the threshold
//   sample_cnt             samples folded into the stats
//   sat                    sticky: a sum clamped during this batch
//   done                   batch complete, stats final
// ---------------------------------------------------------------------------
module arf_error_monitor
   import arf_pkg::*;
#(
   parameter int DATA_W    = ARF_DATA_W,
   parameter int ACC_W     = 80,
   parameter int CNT_W     = 16,
   parameter int N_SAMPLES = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] err_thresh,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] out_27_acc,
   input  logic [DATA_W-1:0] out_27_var,
   input  logic [DATA_W-1:0] out_28_acc,
   input  logic [DATA_W-1:0] out_28_var,
   output logic [ACC_W-1:0]  sum_err_27,
   output logic [ACC_W-1:0]  sum_err_28,
   output logic [DATA_W-1:0] max_err_27,
   output logic [DATA_W-1:0] max_err_28,
   output logic [CNT_W-1:0]  mism_cnt,
   output logic [CNT_W-1:0]  sample_cnt,
   output logic              sat,
   output logic              done
);

   localparam int SW = ACC_W + 1;

   arf_state_t        state;
   logic [CNT_W-1:0]  acc_cnt;
   logic              accept;
   logic              clear;
   logic              s1_valid;
   logic              v27;
   logic              v28;
   logic [DATA_W-1:0] d27;
   logic [DATA_W-1:0] d28;
   logic [DATA_W-1:0] thr_q;
   logic              last_write;
   logic [SW-1:0]     sum27_ext;
   logic [SW-1:0]     sum28_ext;

   // Accepting is gated purely by registered state, so in_ready never
   // depends on in_valid.
   assign in_ready   = (state == RUN) && (acc_cnt < CNT_W'(N_SAMPLES));
   assign accept     = in_valid & in_ready;
   assign clear      = start && (state != RUN);
   assign s1_valid   = v27 & v28;
   assign last_write = s1_valid && (sample_cnt == CNT_W'(N_SAMPLES - 1));

   // One extra bit on each sum exposes the carry used for saturation.
   assign sum27_ext  = {1'b0, sum_err_27} + SW'(d27);
   assign sum28_ext  = {1'b0, sum_err_28} + SW'(d28);

   arf_absdiff #(.W(DATA_W)) u_diff_27 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (accept),
      .a         (out_27_acc),
      .b         (out_27_var),
      .out_valid (v27),
      .diff      (d27)
   );

   arf_absdiff #(.W(DATA_W)) u_diff_28 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (accept),
      .a         (out_28_acc),
      .b         (out_28_var),
      .out_valid (v28),
      .diff      (d28)
   );

   // Batch controller. DONE is entered on the same edge that writes the
   // final sample's stats, so done and the final values appear together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc_cnt <= '0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state   <= RUN;
                  acc_cnt <= '0;
                  done    <= 1'b0;
               end
            end
            RUN: begin
               if (accept) begin
                  acc_cnt <= acc_cnt + 1'b1;
               end
               if (last_write) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // The threshold travels with its sample through stage 1 so that a
   // threshold change mid-batch only affects later samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         thr_q <= '0;
      end else if (accept) begin
         thr_q <= err_thresh;
      end
   end

   // Stage 2: fold one stage-1 result into the statistics. A start that
   // clears the stats can only arrive outside RUN, when nothing is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_err_27 <= '0;
         sum_err_28 <= '0;
         max_err_27 <= '0;
         max_err_28 <= '0;
         mism_cnt   <= '0;
         sample_cnt <= '0;
         sat        <= 1'b0;
      end else if (clear) begin
         sum_err_27 <= '0;
         sum_err_28 <= '0;
         max_err_27 <= '0;
         max_err_28 <= '0;
         mism_cnt   <= '0;
         sample_cnt <= '0;
         sat        <= 1'b0;
      end else if (s1_valid) begin
         sum_err_27 <= sum27_ext[ACC_W] ? {ACC_W{1'b1}} : sum27_ext[ACC_W-1:0];
         sum_err_28 <= sum28_ext[ACC_W] ? {ACC_W{1'b1}} : sum28_ext[ACC_W-1:0];
         if (sum27_ext[ACC_W] || sum28_ext[ACC_W]) begin
            sat <= 1'b1;
         end
         if (d27 > max_err_27) begin
            max_err_27 <= d27;
         end
         if (d28 > max_err_28) begin
            max_err_28 <= d28;
         end
         if ((d27 > thr_q) || (d28 > thr_q)) begin
            mism_cnt <= mism_cnt + 1'b1;
         end
         sample_cnt <= sample_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_arf_error_monitor.sv
// ---------------------------------------------------------------------------
// tb_arf_error_monitor
// Directed and randomised bench for arf_error_monitor. A main instance
// (N_SAMPLES=4, ACC_W=80) is tracked against a reference model through a
// scoreboard; a second instance (ACC_W=64, N_SAMPLES=2) shares the inputs
// and is used to exercise accumulator saturation.
// ---------------------------------------------------------------------------
module tb_arf_error_monitor;
   import arf_pkg::*;

   localparam int N  = 4;
   localparam int AW = 80;

   typedef struct {
      int          due;
      logic [79:0] s27;
      logic [79:0] s28;
      logic [63:0] m27;
      logic [63:0] m28;
      logic [15:0] mc;
      logic [15:0] sc;
      logic        st;
      logic        dn;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [63:0] err_thresh;
   logic        in_valid;
   logic [63:0] out_27_acc, out_27_var, out_28_acc, out_28_var;

   logic        in_ready;
   logic [79:0] sum_err_27, sum_err_28;
   logic [63:0] max_err_27, max_err_28;
   logic [15:0] mism_cnt, sample_cnt;
   logic        sat, done;

   logic        in_ready_b;
   logic [63:0] sum_err_27_b, sum_err_28_b;
   logic [63:0] max_err_27_b, max_err_28_b;
   logic [15:0] mism_cnt_b, sample_cnt_b;
   logic        sat_b, done_b;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   exp_t        sb[$];

   // Reference model state
   int          m_st;
   int          m_acc;
   logic [79:0] m_s27, m_s28;
   logic [63:0] m_m27, m_m28;
   logic [15:0] m_mc, m_sc;
   logic        m_sat;

   always #5 clk = ~clk;

   arf_error_monitor #(.DATA_W(64), .ACC_W(AW), .CNT_W(16), .N_SAMPLES(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .err_thresh(err_thresh),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_27_acc(out_27_acc), .out_27_var(out_27_var),
      .out_28_acc(out_28_acc), .out_28_var(out_28_var),
      .sum_err_27(sum_err_27), .sum_err_28(sum_err_28),
      .max_err_27(max_err_27), .max_err_28(max_err_28),
      .mism_cnt(mism_cnt), .sample_cnt(sample_cnt), .sat(sat), .done(done)
   );

   arf_error_monitor #(.DATA_W(64), .ACC_W(64), .CNT_W(16), .N_SAMPLES(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .err_thresh(err_thresh),
      .in_valid(in_valid), .in_ready(in_ready_b),
      .out_27_acc(out_27_acc), .out_27_var(out_27_var),
      .out_28_acc(out_28_acc), .out_28_var(out_28_var),
      .sum_err_27(sum_err_27_b), .sum_err_28(sum_err_28_b),
      .max_err_27(max_err_27_b), .max_err_28(max_err_28_b),
      .mism_cnt(mism_cnt_b), .sample_cnt(sample_cnt_b), .sat(sat_b), .done(done_b)
   );

   // Guard against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Magnitude via signed arithmetic on widened operands
   function automatic logic [63:0] absd(input logic [63:0] a, input logic [63:0] b);
      logic signed [65:0] t;
      t = $signed({2'b00, a}) - $signed({2'b00, b});
      if (t < 0) t = -t;
      return t[63:0];
   endfunction

   function automatic logic [79:0] satAdd(input logic [79:0] s, input logic [63:0] d, output logic ov);
      logic [80:0] t;
      t  = {1'b0, s} + {17'd0, d};
      ov = (t > 81'h0_FFFF_FFFF_FFFF_FFFF_FFFF);
      return ov ? {80{1'b1}} : t[79:0];
   endfunction

   task automatic modelClear();
      m_acc = 0; m_s27 = '0; m_s28 = '0; m_m27 = '0; m_m28 = '0;
      m_mc = '0; m_sc = '0; m_sat = 1'b0;
   endtask

   task automatic checkOutput(input exp_t e);
      chk("sum_err_27", sum_err_27, e.s27);
      chk("sum_err_28", sum_err_28, e.s28);
      chk("max_err_27", 80'(max_err_27), 80'(e.m27));
      chk("max_err_28", 80'(max_err_28), 80'(e.m28));
      chk("mism_cnt", 80'(mism_cnt), 80'(e.mc));
      chk("sample_cnt", 80'(sample_cnt), 80'(e.sc));
      chk("sat", 80'(sat), 80'(e.st));
      chk("done", 80'(done), 80'(e.dn));
      if (e.dn) m_st = 2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One cycle: drive inputs, predict the handshake, push expected stats
   // for accepts and clears, advance the clock and retire due entries.
   task automatic applyStimulus(input logic v, input logic [63:0] a27, input logic [63:0] v27,
                                input logic [63:0] a28, input logic [63:0] v28,
                                input logic [63:0] thr, input logic st);
      logic        exp_rdy;
      logic        ov27, ov28;
      logic [63:0] d27, d28;
      exp_t        e;
      in_valid = v; start = st; err_thresh = thr;
      out_27_acc = a27; out_27_var = v27; out_28_acc = a28; out_28_var = v28;
      exp_rdy = (m_st == 1) && (m_acc < N);
      chk("in_ready", 80'(in_ready), 80'(exp_rdy));
      if (v && exp_rdy) begin
         d27 = absd(a27, v27);
         d28 = absd(a28, v28);
         m_acc++;
         m_s27 = satAdd(m_s27, d27, ov27);
         m_s28 = satAdd(m_s28, d28, ov28);
         if (ov27 || ov28) m_sat = 1'b1;
         if (d27 > m_m27) m_m27 = d27;
         if (d28 > m_m28) m_m28 = d28;
         if (d27 > thr || d28 > thr) m_mc++;
         m_sc++;
         e = '{cyc + 2, m_s27, m_s28, m_m27, m_m28, m_mc, m_sc, m_sat, (m_acc == N)};
         sb.push_back(e);
      end
      if (st && m_st != 1) begin
         modelClear();
         m_st = 1;
         e = '{cyc + 1, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0};
         sb.push_back(e);
      end
      tick();
      start = 1'b0; in_valid = 1'b0;
      while (sb.size() != 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         checkOutput(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0);
   endtask

   // Idle until the batch completes (bounded) and confirm done
   task automatic drain(input string tag);
      for (int i = 0; i < 8 && m_st != 2; i++) idle(1);
      chk(tag, 80'(done), 80'(1));
   endtask

   initial begin
      logic [63:0] r27a, r27v, r28a, r28v, rthr;
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; err_thresh = '0;
      out_27_acc = '0; out_27_var = '0; out_28_acc = '0; out_28_var = '0;
      m_st = 0;
      modelClear();
      tick(); tick();

      // Reset state
      chk("rst_in_ready", 80'(in_ready), 80'(0));
      chk("rst_done", 80'(done), 80'(0));
      chk("rst_sum_err_27", sum_err_27, 80'(0));
      chk("rst_sample_cnt", 80'(sample_cnt), 80'(0));
      chk("rst_sat", 80'(sat), 80'(0));
      rst_n = 1'b1;
      tick();

      // Saturation on the 64-bit accumulator instance; the main instance
      // folds the same large diffs without clamping.
      $display("[TB] saturation");
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1);
      applyStimulus(1'b1, 64'd0, '1, 64'd0, '1, 64'd5, 1'b0);
      applyStimulus(1'b1, 64'd0, '1, 64'd0, '1, 64'd5, 1'b0);
      applyStimulus(1'b1, 64'd7, 64'd7, 64'd7, 64'd7, 64'd5, 1'b0);
      applyStimulus(1'b1, 64'd7, 64'd7, 64'd7, 64'd7, 64'd5, 1'b0);
      chk("sat_b", 80'(sat_b), 80'(1));
      chk("sum_err_27_b", 80'(sum_err_27_b), 80'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("sum_err_28_b", 80'(sum_err_28_b), 80'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("max_err_27_b", 80'(max_err_27_b), 80'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("mism_cnt_b", 80'(mism_cnt_b), 80'(2));
      chk("sample_cnt_b", 80'(sample_cnt_b), 80'(2));
      chk("done_b", 80'(done_b), 80'(1));
      drain("sat_batch_done");

      // All pairs equal
      $display("[TB] equal pairs");
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1);
      for (int i = 0; i < N; i++)
         applyStimulus(1'b1, 64'(i * 11), 64'(i * 11), 64'(i + 3), 64'(i + 3), 64'd0, 1'b0);
      drain("equal_done");

      // Fixed diffs of 3 and 4 against thresholds 3 and 4
      $display("[TB] threshold 3");
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1);
      for (int i = 0; i < N; i++)
         applyStimulus(1'b1, 64'd100, 64'd97, 64'd5, 64'd9, 64'd3, 1'b0);
      drain("thr3_done");
      chk("thr3_mism_cnt", 80'(mism_cnt), 80'(4));
      chk("thr3_sum_err_28", sum_err_28, 80'(16));
      $display("[TB] threshold 4");
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1);
      for (int i = 0; i < N; i++)
         applyStimulus(1'b1, 64'd100, 64'd97, 64'd5, 64'd9, 64'd4, 1'b0);
      drain("thr4_done");
      chk("thr4_mism_cnt", 80'(mism_cnt), 80'(0));

      // in_valid held through DONE; samples after N are not counted
      $display("[TB] valid held past batch");
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1);
      for (int i = 0; i < N + 7; i++)
         applyStimulus(1'b1, 64'(i), 64'(2 * i), 64'(50 - i), 64'(i), 64'd10, 1'b0);
      chk("held_sample_cnt", 80'(sample_cnt), 80'(N));
      chk("held_done", 80'(done), 80'(1));

      // start in RUN is ignored
      $display("[TB] start in RUN");
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1);
      applyStimulus(1'b1, 64'd9, 64'd1, 64'd1, 64'd9, 64'd7, 1'b0);
      applyStimulus(1'b1, 64'd20, 64'd1, 64'd2, 64'd2, 64'd7, 1'b0);
      applyStimulus(1'b1, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 1'b1);
      applyStimulus(1'b1, 64'd30, 64'd4, 64'd8, 64'd6, 64'd7, 1'b0);
      drain("run_start_done");
      chk("run_start_sample_cnt", 80'(sample_cnt), 80'(N));

      // Asynchronous reset mid-batch with samples in flight
      $display("[TB] reset mid-batch");
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1);
      applyStimulus(1'b1, 64'd40, 64'd1, 64'd1, 64'd40, 64'd0, 1'b0);
      applyStimulus(1'b1, 64'd50, 64'd1, 64'd1, 64'd50, 64'd0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_sum_err_27", sum_err_27, 80'(0));
      chk("arst_sample_cnt", 80'(sample_cnt), 80'(0));
      chk("arst_in_ready", 80'(in_ready), 80'(0));
      chk("arst_done", 80'(done), 80'(0));
      m_st = 0;
      modelClear();
      sb.delete();
      tick();
      rst_n = 1'b1;
      idle(2);

      // Random valid and data across many batches
      $display("[TB] random batches");
      for (int b = 0; b < 30; b++) begin
         applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1);
         for (int i = 0; i < 60 && m_st != 2; i++) begin
            r27a = {$urandom, $urandom};
            r27v = (b % 3 == 0) ? {$urandom, $urandom} : r27a + 64'($urandom_range(0, 200)) - 64'd100;
            r28a = {$urandom, $urandom};
            r28v = (b % 2 == 0) ? {$urandom, $urandom} : r28a - 64'($urandom_range(0, 50));
            rthr = (b % 4 == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 120));
            applyStimulus(1'($urandom_range(0, 1)), r27a, r27v, r28a, r28v, rthr, 1'b0);
         end
         chk("rand_done", 80'(done), 80'(1));
      end

      chk("scoreboard_empty", 80'(sb.size()), 80'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
